// File: rtl/ips2l_pcie_dma_rx_bar_wr_router.sv
// RX BAR write router: two queued write-beat sources (MWR, CPLD) steered to NUM_BARS
// BAR RAM write ports by per-beat BAR index, with round-robin on same-BAR collisions.
module ips2l_pcie_dma_rx_bar_wr_router #(
    parameter int NUM_BARS   = 3,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_src0_vld,
    output logic                               o_src0_rdy,
    input  logic [2:0]                         i_src0_bar,
    input  logic [ADDR_WIDTH-1:0]              i_src0_addr,
    input  logic [DATA_WIDTH-1:0]              i_src0_data,
    input  logic [DATA_WIDTH/8-1:0]            i_src0_be,
    input  logic                               i_src1_vld,
    output logic                               o_src1_rdy,
    input  logic [2:0]                         i_src1_bar,
    input  logic [ADDR_WIDTH-1:0]              i_src1_addr,
    input  logic [DATA_WIDTH-1:0]              i_src1_data,
    input  logic [DATA_WIDTH/8-1:0]            i_src1_be,
    output logic [NUM_BARS-1:0]                o_bar_wr_en,
    output logic [NUM_BARS*ADDR_WIDTH-1:0]     o_bar_wr_addr,
    output logic [NUM_BARS*DATA_WIDTH-1:0]     o_bar_wr_data,
    output logic [NUM_BARS*DATA_WIDTH/8-1:0]   o_bar_wr_be,
    input  logic                               i_cnt_clr,
    output logic [15:0]                        o_drop_cnt,
    output logic                               o_bar_err,
    output logic                               o_busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W   = 3 + ADDR_WIDTH + DATA_WIDTH + BE_WIDTH;
    localparam logic [3:0] BAR_LIMIT = 4'(NUM_BARS);

    logic [1:0]                 push, pop, empty, full;
    logic [1:0]                 valid, bad_bar, drop, route, grant;
    logic                       collide;
    logic                       rr;
    logic [16:0]                cnt_sum;
    logic [1:0][BEAT_W-1:0]     in_beat, head;
    logic [1:0][2:0]            h_bar;
    logic [1:0][ADDR_WIDTH-1:0] h_addr;
    logic [1:0][DATA_WIDTH-1:0] h_data;
    logic [1:0][BE_WIDTH-1:0]   h_be;

    assign in_beat[0] = {i_src0_bar, i_src0_addr, i_src0_data, i_src0_be};
    assign in_beat[1] = {i_src1_bar, i_src1_addr, i_src1_data, i_src1_be};

    // rdy comes from registered pointers only, so a same-cycle pop never reopens a full FIFO.
    assign o_src0_rdy = ~full[0];
    assign o_src1_rdy = ~full[1];
    assign push[0]    = i_src0_vld & ~full[0];
    assign push[1]    = i_src1_vld & ~full[1];
    assign o_busy     = ~(&empty);

    for (genvar s = 0; s < 2; s++) begin : g_fifo
        logic [BEAT_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[s]) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop[s])  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (push[s]) mem[wr_ptr[PTR_W-2:0]] <= in_beat[s];
        end

        assign empty[s] = (wr_ptr == rd_ptr);
        assign full[s]  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                          (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
        assign head[s]  = mem[rd_ptr[PTR_W-2:0]];
        assign {h_bar[s], h_addr[s], h_data[s], h_be[s]} = head[s];
    end

    always_comb begin
        valid   = '0;
        bad_bar = '0;
        drop    = '0;
        route   = '0;
        for (int s = 0; s < 2; s++) begin
            valid[s]   = ~empty[s];
            bad_bar[s] = valid[s] && ({1'b0, h_bar[s]} >= BAR_LIMIT);
            drop[s]    = valid[s] && (bad_bar[s] || (h_be[s] == '0));
            route[s]   = valid[s] && !drop[s];
        end
        collide  = route[0] && route[1] && (h_bar[0] == h_bar[1]);
        grant[0] = route[0] && (!collide || !rr);
        grant[1] = route[1] && (!collide || rr);
        pop      = drop | grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rr <= 1'b0;
        else if (collide) rr <= ~rr;
    end

    assign cnt_sum = {1'b0, o_drop_cnt} + 17'(drop[0]) + 17'(drop[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_drop_cnt <= '0;
            o_bar_err  <= 1'b0;
        end else if (i_cnt_clr) begin
            o_drop_cnt <= '0;
            o_bar_err  <= 1'b0;
        end else begin
            o_drop_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if (|bad_bar) o_bar_err <= 1'b1;
        end
    end

    // Payload slices are only loaded on a strobe so idle ports keep their last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_bar_wr_en   <= '0;
            o_bar_wr_addr <= '0;
            o_bar_wr_data <= '0;
            o_bar_wr_be   <= '0;
        end else begin
            for (int k = 0; k < NUM_BARS; k++) begin
                o_bar_wr_en[k] <= (grant[0] && (h_bar[0] == 3'(k))) ||
                                  (grant[1] && (h_bar[1] == 3'(k)));
                if (grant[0] && (h_bar[0] == 3'(k))) begin
                    o_bar_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] <= h_addr[0];
                    o_bar_wr_data[k*DATA_WIDTH +: DATA_WIDTH] <= h_data[0];
                    o_bar_wr_be[k*BE_WIDTH +: BE_WIDTH]       <= h_be[0];
                end else if (grant[1] && (h_bar[1] == 3'(k))) begin
                    o_bar_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] <= h_addr[1];
                    o_bar_wr_data[k*DATA_WIDTH +: DATA_WIDTH] <= h_data[1];
                    o_bar_wr_be[k*BE_WIDTH +: BE_WIDTH]       <= h_be[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_ips2l_pcie_dma_rx_bar_wr_router.sv
// Bench for the RX BAR write router: directed vector table, hand-written corner
// sequences, and randomized traffic scored against a per-source queue model.
module tb_ips2l_pcie_dma_rx_bar_wr_router;

    localparam int NB = 3;
    localparam int AW = 9;
    localparam int DW = 128;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              src0_vld, src1_vld, src0_rdy, src1_rdy;
    logic [2:0]        src0_bar, src1_bar;
    logic [AW-1:0]     src0_addr, src1_addr;
    logic [DW-1:0]     src0_data, src1_data;
    logic [BW-1:0]     src0_be, src1_be;
    logic [NB-1:0]     bar_wr_en;
    logic [NB*AW-1:0]  bar_wr_addr;
    logic [NB*DW-1:0]  bar_wr_data;
    logic [NB*BW-1:0]  bar_wr_be;
    logic              cnt_clr;
    logic [15:0]       drop_cnt;
    logic              bar_err, busy;

    always #5 clk = ~clk;

    ips2l_pcie_dma_rx_bar_wr_router #(
        .NUM_BARS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_src0_vld(src0_vld), .o_src0_rdy(src0_rdy), .i_src0_bar(src0_bar),
        .i_src0_addr(src0_addr), .i_src0_data(src0_data), .i_src0_be(src0_be),
        .i_src1_vld(src1_vld), .o_src1_rdy(src1_rdy), .i_src1_bar(src1_bar),
        .i_src1_addr(src1_addr), .i_src1_data(src1_data), .i_src1_be(src1_be),
        .o_bar_wr_en(bar_wr_en), .o_bar_wr_addr(bar_wr_addr),
        .o_bar_wr_data(bar_wr_data), .o_bar_wr_be(bar_wr_be),
        .i_cnt_clr(cnt_clr), .o_drop_cnt(drop_cnt), .o_bar_err(bar_err), .o_busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] slice_addr(input int k);
        return bar_wr_addr[k*AW +: AW];
    endfunction
    function automatic logic [DW-1:0] slice_data(input int k);
        return bar_wr_data[k*DW +: DW];
    endfunction
    function automatic logic [BW-1:0] slice_be(input int k);
        return bar_wr_be[k*BW +: BW];
    endfunction

    task automatic idle();
        src0_vld = 0; src0_bar = 0; src0_addr = 0; src0_data = 0; src0_be = 0;
        src1_vld = 0; src1_bar = 0; src1_addr = 0; src1_data = 0; src1_be = 0;
        cnt_clr  = 0;
    endtask

    task automatic drive(input int s, input logic v, input logic [2:0] b,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        if (s == 0) begin
            src0_vld = v; src0_bar = b; src0_addr = a; src0_data = d; src0_be = be;
        end else begin
            src1_vld = v; src1_bar = b; src1_addr = a; src1_data = d; src1_be = be;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    task automatic clear_cnt();
        @(negedge clk); cnt_clr = 1;
        @(negedge clk); cnt_clr = 0;
    endtask

    // Reference model: each source's routable beats in push order; writes must drain in that order.
    typedef struct packed {
        logic [2:0]    bar;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } beat_t;
    beat_t q0[$];
    beat_t q1[$];
    int    m_drops;
    logic  m_err;

    task automatic model_push(input int s, input beat_t b);
        if (b.bar >= 3'(NB) || b.be == '0) begin
            m_drops++;
            if (b.bar >= 3'(NB)) m_err = 1'b1;
        end else if (s == 0) q0.push_back(b);
        else                 q1.push_back(b);
    endtask

    task automatic score_strobes();
        beat_t e;
        int    s;
        for (int k = 0; k < NB; k++) begin
            if (bar_wr_en[k]) begin
                s = int'(slice_data(k)[DW-1]);
                if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
                    n_chk++; n_fail++;
                    $display("FAIL rnd_unexpected: strobe on BAR %0d from src%0d, expected none", k, s);
                end else begin
                    e = (s == 0) ? q0.pop_front() : q1.pop_front();
                    chk("rnd_bar",  32'(k),       32'(e.bar));
                    chk("rnd_addr", slice_addr(k), e.addr);
                    chk("rnd_data", slice_data(k), e.data);
                    chk("rnd_be",   slice_be(k),   e.be);
                end
            end
        end
    endtask

    typedef struct {
        logic          v0;
        logic [2:0]    b0;
        logic [BW-1:0] be0;
        logic          v1;
        logic [2:0]    b1;
        logic [BW-1:0] be1;
        logic          first1;
        logic [NB-1:0] en_a;
        logic [NB-1:0] en_b;
        int            drops;
        logic          err;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic          tgt0, tgt1, es, seen;
        logic [AW-1:0] ea;
        beat_t         b;
        int            pushes0, pushes1;

        vt[0] = '{1, 0, 16'hFFFF, 1, 2, 16'hFFFF, 0, 3'b101, 3'b000, 0, 0};
        vt[1] = '{1, 1, 16'h00F0, 0, 0, 16'h0000, 0, 3'b010, 3'b000, 0, 0};
        vt[2] = '{1, 5, 16'hFFFF, 1, 2, 16'h000F, 0, 3'b100, 3'b000, 1, 1};
        vt[3] = '{1, 2, 16'h0000, 1, 0, 16'h8001, 0, 3'b001, 3'b000, 1, 0};
        vt[4] = '{1, 1, 16'hFFFF, 1, 1, 16'hFFFF, 0, 3'b010, 3'b010, 0, 0};
        vt[5] = '{1, 7, 16'hFFFF, 1, 7, 16'h1234, 0, 3'b000, 3'b000, 2, 1};
        vt[6] = '{1, 3, 16'hFFFF, 1, 2, 16'h0000, 0, 3'b000, 3'b000, 2, 1};
        vt[7] = '{1, 0, 16'h0F0F, 1, 0, 16'hF0F0, 1, 3'b001, 3'b001, 0, 0};

        idle();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);

        chk("rst_en",   bar_wr_en, 0);
        chk("rst_rdy0", src0_rdy, 1);
        chk("rst_rdy1", src1_rdy, 1);
        chk("rst_cnt",  drop_cnt, 0);
        chk("rst_err",  bar_err, 0);
        chk("rst_busy", busy, 0);

        // Directed vectors: one beat per source, strobes checked 2 and 3 cycles later.
        for (int i = 0; i < 8; i++) begin
            clear_cnt();
            drive(0, vt[i].v0, vt[i].b0, AW'(9'h010 + i), {1'b0, 127'(i)},    vt[i].be0);
            drive(1, vt[i].v1, vt[i].b1, AW'(9'h020 + i), {1'b1, 127'(i+64)}, vt[i].be1);
            @(negedge clk); idle();
            @(negedge clk);
            chk($sformatf("vec%0d_en_a", i), bar_wr_en, vt[i].en_a);
            for (int k = 0; k < NB; k++) begin
                if (vt[i].en_a[k]) begin
                    tgt0 = vt[i].v0 && vt[i].b0 == 3'(k) && vt[i].be0 != 0;
                    tgt1 = vt[i].v1 && vt[i].b1 == 3'(k) && vt[i].be1 != 0;
                    es   = (tgt0 && tgt1) ? vt[i].first1 : tgt1;
                    ea   = es ? AW'(9'h020 + i) : AW'(9'h010 + i);
                    chk($sformatf("vec%0d_addr_a", i), slice_addr(k), ea);
                    chk($sformatf("vec%0d_data_a", i), slice_data(k),
                        es ? {1'b1, 127'(i+64)} : {1'b0, 127'(i)});
                end
            end
            @(negedge clk);
            chk($sformatf("vec%0d_en_b", i), bar_wr_en, vt[i].en_b);
            for (int k = 0; k < NB; k++) begin
                if (vt[i].en_b[k]) begin
                    ea = vt[i].first1 ? AW'(9'h010 + i) : AW'(9'h020 + i);
                    chk($sformatf("vec%0d_addr_b", i), slice_addr(k), ea);
                end
            end
            chk($sformatf("vec%0d_drops", i), drop_cnt, 128'(vt[i].drops));
            chk($sformatf("vec%0d_err", i),   bar_err,  vt[i].err);
        end

        // Hold: BAR2 slice keeps the last payload with en low.
        @(negedge clk);
        chk("hold_en",   bar_wr_en[2], 0);
        chk("hold_addr", slice_addr(2), AW'(9'h022));

        // Both sources stream 4 beats to BAR1 from reset: 8 back-to-back alternating writes.
        do_reset();
        for (int t = 0; t < 12; t++) begin
            if (t >= 2 && t < 10) begin
                chk($sformatf("strm_en%0d", t-2), bar_wr_en, 3'b010);
                ea = ((t - 2) % 2 == 0) ? AW'(9'h100 + (t-2)/2) : AW'(9'h180 + (t-2)/2);
                chk($sformatf("strm_addr%0d", t-2), slice_addr(1), ea);
            end
            if (t == 10) chk("strm_done", bar_wr_en, 0);
            if (t < 4) begin
                drive(0, 1, 1, AW'(9'h100 + t), {1'b0, 127'(t)}, 16'hFFFF);
                drive(1, 1, 1, AW'(9'h180 + t), {1'b1, 127'(t)}, 16'hFFFF);
            end else idle();
            @(negedge clk);
        end

        // Drop handling and counter clear.
        clear_cnt();
        drive(1, 1, 5, 9'h033, {1'b1, 127'h5}, 16'hFFFF);
        @(negedge clk);
        drive(1, 1, 1, 9'h034, {1'b1, 127'h6}, 16'h0000);
        @(negedge clk); idle();
        for (int t = 0; t < 3; t++) begin
            chk("drop_no_strobe", bar_wr_en, 0);
            @(negedge clk);
        end
        chk("drop_cnt2", drop_cnt, 2);
        chk("drop_err",  bar_err, 1);
        cnt_clr = 1;
        @(negedge clk); cnt_clr = 0;
        chk("clr_cnt", drop_cnt, 0);
        chk("clr_err", bar_err, 0);

        // Fill FIFOs behind BAR0 collisions, then reset mid-operation.
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (!src0_rdy) seen = 1;
            else begin
                drive(0, 1, 0, AW'(9'h040 + t), {1'b0, 127'(t)}, 16'hFFFF);
                drive(1, 1, 0, AW'(9'h060 + t), {1'b1, 127'(t)}, 16'hFFFF);
                @(negedge clk);
            end
        end
        chk("fill_rdy0_low", seen, 1);
        chk("fill_busy", busy, 1);
        idle(); rst = 1;
        @(negedge clk); rst = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("post_rst_en",   bar_wr_en, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_rdy",  {src0_rdy, src1_rdy}, 2'b11);
        end

        // Randomized traffic against the per-source queue model.
        do_reset();
        q0.delete(); q1.delete();
        m_drops = 0; m_err = 0;
        for (int t = 0; t < 3000; t++) begin
            score_strobes();
            for (int s = 0; s < 2; s++) begin
                b.bar  = 3'($urandom_range(0, 4));
                b.addr = AW'($urandom);
                b.data = {$urandom, $urandom, $urandom, $urandom};
                b.data[DW-1:DW-16] = {1'(s), 15'(t)};
                b.be   = ($urandom % 6 == 0) ? '0 : BW'($urandom);
                drive(s, ($urandom % 4) != 0, b.bar, b.addr, b.data, b.be);
                if ((s == 0 && src0_vld && src0_rdy) || (s == 1 && src1_vld && src1_rdy))
                    model_push(s, b);
            end
            @(negedge clk);
        end
        idle();
        for (int t = 0; t < 40; t++) begin
            score_strobes();
            @(negedge clk);
        end
        chk("rnd_busy",   busy, 0);
        chk("rnd_q0",     q0.size(), 0);
        chk("rnd_q1",     q1.size(), 0);
        chk("rnd_drops",  drop_cnt, 128'(m_drops));
        chk("rnd_err",    bar_err, m_err);

        // Saturation: 65534 drops, then 3 more.
        do_reset();
        pushes0 = 0; pushes1 = 0;
        for (int t = 0; t < 40000 && (pushes0 + pushes1) < 65534; t++) begin
            idle();
            if (src0_rdy && (pushes0 + pushes1) < 65534) begin
                drive(0, 1, 7, 0, 0, 16'hFFFF); pushes0++;
            end
            if (src1_rdy && (pushes0 + pushes1) < 65534) begin
                drive(1, 1, 3'(NB), 0, 0, 16'hFFFF); pushes1++;
            end
            @(negedge clk);
        end
        idle();
        repeat (6) @(negedge clk);
        chk("sat_fffe", drop_cnt, 16'hFFFE);
        for (int t = 0; t < 3; t++) begin
            drive(0, 1, 1, 0, 0, 16'h0000);
            @(negedge clk);
        end
        idle();
        repeat (6) @(negedge clk);
        chk("sat_ffff", drop_cnt, 16'hFFFF);
        chk("sat_no_strobe", bar_wr_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
